gauss_clt_sampler: RTL and testbench

// - Consumes the 16-bit uniform stream from the LFSR random generator and builds one

---
 rtl/gauss_clt_sampler.sv | 151 +++++++++++++++
 tb/tb_gauss_clt_sampler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_clt_sampler.sv
// Purpose : sums 2**LOG2_N uniform samples into an approximately Gaussian eps (CLT),
//           then outputs y = sat(mu + (sigma*eps >>> (OUT_W-1))) as signed OUT_W bits.
// Latency : the Nth accepted sample is followed by one SCALE cycle, then out_valid is held.
// Backpressure: rand_ready only in ACCUM; gauss_out/eps_out are held until out_valid & out_ready.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   rand_in/_valid/_ready    uniform input stream (valid/ready handshake)
//   mu, sigma                signed mean / unsigned scale (x/2**(OUT_W-1)), latched per group
//   out_valid/out_ready      output handshake
//   gauss_out, eps_out       signed reparameterised sample and unit-normal estimate
module gauss_clt_sampler #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 2,
    parameter int OUT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] rand_in,
    input  logic              rand_valid,
    output logic              rand_ready,
    input  logic [OUT_W-1:0]  mu,
    input  logic [OUT_W-1:0]  sigma,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  gauss_out,
    output logic [OUT_W-1:0]  eps_out
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int SHIFT = ACC_W - OUT_W;
    localparam int P_W   = 2 * OUT_W + 1;
    localparam int Y_W   = P_W + 1;

    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [Y_W-1:0] Y_MIN = -Y_MAX - Y_W'(1);

    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_SCALE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [LOG2_N-1:0] count_q,     count_d;
    logic [ACC_W-1:0]  acc_q,       acc_d;
    logic [OUT_W-1:0]  mu_q,        mu_d;
    logic [OUT_W-1:0]  sigma_q,     sigma_d;
    logic [OUT_W-1:0]  gauss_q,     gauss_d;
    logic [OUT_W-1:0]  eps_q,       eps_d;
    logic              out_valid_q, out_valid_d;

    logic signed [OUT_W-1:0] eps;
    logic signed [P_W-1:0]   prod;
    logic signed [Y_W-1:0]   y_full;
    logic [OUT_W-1:0]        y_sat;

    assign rand_ready = (state_q == ST_ACCUM) && !reset;
    assign out_valid  = out_valid_q;
    assign gauss_out  = gauss_q;
    assign eps_out    = eps_q;

    // The bias N*2**(DATA_W-1) equals 2**(ACC_W-1), a single bit at the top of acc.
    // Since SHIFT < ACC_W-1 the bias has no bits below the shift point, so
    // (acc - bias) >>> SHIFT is just acc[ACC_W-1:SHIFT] with its MSB inverted
    // (offset-binary to two's complement). This is exactly floor division.
    always_comb begin
        eps    = {~acc_q[ACC_W-1], acc_q[ACC_W-2:SHIFT]};
        prod   = P_W'($signed({1'b0, sigma_q})) * P_W'(eps);
        y_full = Y_W'($signed(mu_q)) + Y_W'(prod >>> (OUT_W - 1));
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[OUT_W-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[OUT_W-1:0];
        end else begin
            y_sat = y_full[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mu_d        = mu_q;
        sigma_d     = sigma_q;
        gauss_d     = gauss_q;
        eps_d       = eps_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACCUM: begin
                if (rand_valid && rand_ready) begin
                    // First sample of a group loads acc and freezes mu/sigma for the group.
                    if (count_q == '0) begin
                        acc_d   = ACC_W'(rand_in);
                        mu_d    = mu;
                        sigma_d = sigma;
                    end else begin
                        acc_d = acc_q + ACC_W'(rand_in);
                    end
                    if (count_q == CNT_LAST) begin
                        count_d = '0;
                        state_d = ST_SCALE;
                    end else begin
                        count_d = count_q + LOG2_N'(1);
                    end
                end
            end
            ST_SCALE: begin
                eps_d       = eps;
                gauss_d     = y_sat;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d     = ST_ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            mu_q        <= '0;
            sigma_q     <= '0;
            gauss_q     <= '0;
            eps_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mu_q        <= mu_d;
            sigma_q     <= sigma_d;
            gauss_q     <= gauss_d;
            eps_q       <= eps_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_gauss_clt_sampler.sv
// Purpose : directed self-checking bench for gauss_clt_sampler (N=4, 16-bit in, 8-bit out).
// Latency : stimulus driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: out_ready driven explicitly by each scenario.
module tb_gauss_clt_sampler;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] rand_in;
    logic        rand_valid;
    logic        rand_ready;
    logic [7:0]  mu;
    logic [7:0]  sigma;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  gauss_out;
    logic [7:0]  eps_out;

    int total = 0;
    int bad   = 0;

    gauss_clt_sampler #(.DATA_W(16), .LOG2_N(2), .OUT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .rand_in    (rand_in),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .mu         (mu),
        .sigma      (sigma),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gauss_out  (gauss_out),
        .eps_out    (eps_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] m, input logic [7:0] s);
        rand_in    = d;
        mu         = m;
        sigma      = s;
        rand_valid = 1'b1;
        step();
        rand_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, captures the outputs, then performs one handshake.
    task automatic collect(output logic [7:0] e, output logic [7:0] g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        e = eps_out;
        g = gauss_out;
        if (ok) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (rand_ready !== 1'b0) begin bad++; $display("FAIL reset_rand_ready: got %b want 0", rand_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (gauss_out !== 8'h00) begin bad++; $display("FAIL reset_gauss: got %h want 00", gauss_out); end
        total++; if (eps_out !== 8'h00) begin bad++; $display("FAIL reset_eps: got %h want 00", eps_out); end
        reset = 1'b0;
        #1;
        total++; if (rand_ready !== 1'b1) begin bad++; $display("FAIL post_reset_rand_ready: got %b want 1", rand_ready); end
    endtask

    task automatic test_midscale();
        for (int i = 0; i < 4; i++) push(16'h8000, 8'h00, 8'd128);
        // Cycle after the 4th accept is the SCALE cycle.
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_scale_valid: got %b want 0", out_valid); end
        total++; if (rand_ready !== 1'b0) begin bad++; $display("FAIL mid_scale_ready: got %b want 0", rand_ready); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_latency_valid: got %b want 1", out_valid); end
        total++; if (eps_out !== 8'h00) begin bad++; $display("FAIL mid_eps: got %h want 00", eps_out); end
        total++; if (gauss_out !== 8'h00) begin bad++; $display("FAIL mid_gauss: got %h want 00", gauss_out); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_drop_valid: got %b want 0", out_valid); end
        total++; if (rand_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_back: got %b want 1", rand_ready); end
    endtask

    task automatic test_saturation();
        logic [7:0] e, g;
        bit ok;
        // All-ones: eps = 127, 128*127>>>7 = 127.
        for (int i = 0; i < 4; i++) push(16'hFFFF, 8'd0, 8'd128);
        collect(e, g, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_hi_timeout: got no out_valid want out_valid"); end
        total++; if (e !== 8'd127) begin bad++; $display("FAIL sat_hi_eps: got %h want 7f", e); end
        total++; if (g !== 8'd127) begin bad++; $display("FAIL sat_hi_gauss: got %h want 7f", g); end
        // mu=10: 10+127 = 137 clamps to 127.
        for (int i = 0; i < 4; i++) push(16'hFFFF, 8'd10, 8'd128);
        collect(e, g, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_mu10_timeout: got no out_valid want out_valid"); end
        total++; if (g !== 8'd127) begin bad++; $display("FAIL sat_mu10_gauss: got %h want 7f", g); end
        // All-zeros, sigma=255: eps=-128, p>>>7 = -255, clamps to -128.
        for (int i = 0; i < 4; i++) push(16'h0000, 8'd0, 8'd255);
        collect(e, g, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_lo_timeout: got no out_valid want out_valid"); end
        total++; if (e !== 8'h80) begin bad++; $display("FAIL sat_lo_eps: got %h want 80", e); end
        total++; if (g !== 8'h80) begin bad++; $display("FAIL sat_lo_gauss: got %h want 80", g); end
    endtask

    task automatic test_mixed();
        logic [7:0] e, g;
        bit ok;
        // sum = 0x1E258 = 123480; c = -7592; c>>>10 = -8;
        // p = 200*-8 = -1600; p>>>7 = -13; y = -7 - 13 = -20 (0xEC).
        push(16'h1234, 8'hF9, 8'd200);
        push(16'h5678, 8'h00, 8'd0);
        push(16'h9ABC, 8'h00, 8'd0);
        push(16'hDEF0, 8'h00, 8'd0);
        collect(e, g, ok);
        total++; if (!ok) begin bad++; $display("FAIL mixed_timeout: got no out_valid want out_valid"); end
        total++; if (e !== 8'hF8) begin bad++; $display("FAIL mixed_eps: got %h want f8", e); end
        total++; if (g !== 8'hEC) begin bad++; $display("FAIL mixed_gauss: got %h want ec", g); end
    endtask

    task automatic test_backpressure();
        logic [7:0] e, g;
        bit ok;
        for (int i = 0; i < 4; i++) push(16'hFFFF, 8'd0, 8'd128);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1 (cycle %0d)", out_valid, i); end
            total++; if (gauss_out !== 8'd127 || eps_out !== 8'd127) begin bad++; $display("FAIL bp_hold_data: got %h/%h want 7f/7f (cycle %0d)", gauss_out, eps_out, i); end
            total++; if (rand_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready: got %b want 0 (cycle %0d)", rand_ready, i); end
        end
        collect(e, g, ok);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        total++; if (rand_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", rand_ready); end
    endtask

    task automatic test_bubbles();
        logic [6:0] pat;
        logic [7:0] e, g;
        bit ok;
        int extra;
        pat = 7'b1100101; // applied LSB first: 1,0,1,0,0,1,1
        for (int i = 0; i < 7; i++) begin
            rand_valid = pat[i];
            rand_in    = 16'h8000;
            mu         = (i == 0) ? 8'd5 : 8'hEC;
            sigma      = 8'd128;
            step();
            if (i == 5) begin
                total++; if (out_valid !== 1'b0 || rand_ready !== 1'b1) begin bad++; $display("FAIL bub_early: got valid=%b ready=%b want 0/1", out_valid, rand_ready); end
            end
        end
        rand_valid = 1'b0;
        collect(e, g, ok);
        total++; if (!ok) begin bad++; $display("FAIL bub_timeout: got no out_valid want out_valid"); end
        total++; if (g !== 8'd5) begin bad++; $display("FAIL bub_first_mu: got %h want 05", g); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) extra++;
            step();
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL bub_single_output: got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e, g;
        bit ok;
        push(16'hFFFF, 8'd0, 8'd128);
        push(16'hFFFF, 8'd0, 8'd128);
        reset = 1'b1;
        step();
        reset = 1'b0;
        // Fresh group: 0 + 0 + 0x8000 + 0x8000 = 0x10000; eps = -64; y = 3 - 64 = -61 (0xC3).
        push(16'h0000, 8'd3, 8'd128);
        push(16'h0000, 8'd0, 8'd0);
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_partial_discard: got %b want 0", out_valid); end
        push(16'h8000, 8'd0, 8'd0);
        push(16'h8000, 8'd0, 8'd0);
        collect(e, g, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_timeout: got no out_valid want out_valid"); end
        total++; if (e !== 8'hC0) begin bad++; $display("FAIL rst_eps: got %h want c0", e); end
        total++; if (g !== 8'hC3) begin bad++; $display("FAIL rst_gauss: got %h want c3", g); end
    endtask

    initial begin
        reset      = 1'b1;
        rand_in    = '0;
        rand_valid = 1'b0;
        mu         = '0;
        sigma      = '0;
        out_ready  = 1'b0;
        test_reset();
        test_midscale();
        test_saturation();
        test_mixed();
        test_backpressure();
        test_bubbles();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
